// File: rtl/l2_ifill_arbiter.sv
// Shares the single L2 instruction-fill port between I-cache demand misses and the
// next-line prefetcher, one outstanding line fill at a time.
module l2_ifill_arbiter #(
  parameter int unsigned SIZE_PC       = 32,
  parameter int unsigned LINE_BITS     = 256,
  parameter int unsigned LINE_OFF_BITS = 5,
  parameter int unsigned PF_MAX_SKIP   = 4,
  parameter int unsigned TIMEOUT       = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_i,
  input  logic                 dem_req_i,
  input  logic [SIZE_PC-1:0]   dem_addr_i,
  output logic                 dem_gnt_o,
  output logic                 dem_valid_o,
  input  logic                 pf_req_i,
  input  logic [SIZE_PC-1:0]   pf_addr_i,
  output logic                 pf_gnt_o,
  output logic                 pf_drop_o,
  output logic                 pf_valid_o,
  output logic [LINE_BITS-1:0] rsp_data_o,
  output logic                 mem_re_o,
  output logic [SIZE_PC-1:0]   mem_addr_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ready_i,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int unsigned SKIP_W = $clog2(PF_MAX_SKIP + 1);
  localparam int unsigned WAIT_W = 8;
  localparam logic [SIZE_PC-1:0] LINE_MASK =
    ~((SIZE_PC'(1) << LINE_OFF_BITS) - SIZE_PC'(1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state;
  logic [SKIP_W-1:0]   skip_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [SIZE_PC-1:0]  last_line;
  logic                last_valid;
  logic                owner;

  logic                arb_en;
  logic                pf_force;
  logic                pf_win;
  logic                dem_win;
  logic                pf_redundant;
  logic [SIZE_PC-1:0]  dem_line;
  logic [SIZE_PC-1:0]  pf_line;
  logic [WAIT_W-1:0]   wait_nxt;

  // Arbitration is evaluated combinationally in the IDLE cycle so grants land in cycle N.
  assign dem_line     = dem_addr_i & LINE_MASK;
  assign pf_line      = pf_addr_i & LINE_MASK;
  assign arb_en       = run_i && !reset && (state == S_IDLE);
  assign pf_force     = pf_req_i && (skip_cnt == SKIP_W'(PF_MAX_SKIP));
  assign pf_win       = arb_en && (pf_force || (pf_req_i && !dem_req_i));
  assign dem_win      = arb_en && dem_req_i && !pf_force;
  assign pf_redundant = last_valid && (pf_line == last_line);
  assign wait_nxt     = wait_cnt + WAIT_W'(1);

  assign dem_gnt_o = dem_win;
  assign pf_gnt_o  = pf_win;
  assign pf_drop_o = pf_win && pf_redundant;

  // Fill sequencer: all state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      skip_cnt    <= '0;
      wait_cnt    <= '0;
      last_line   <= '0;
      last_valid  <= 1'b0;
      owner       <= 1'b0;
      rsp_data_o  <= '0;
      mem_addr_o  <= '0;
      mem_re_o    <= 1'b0;
      dem_valid_o <= 1'b0;
      pf_valid_o  <= 1'b0;
      busy_o      <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      mem_re_o    <= 1'b0;
      dem_valid_o <= 1'b0;
      pf_valid_o  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (dem_win) begin
            mem_addr_o <= dem_line;
            owner      <= 1'b0;
            state      <= S_ISSUE;
            busy_o     <= 1'b1;
            mem_re_o   <= 1'b1;
            if (pf_req_i && (skip_cnt != SKIP_W'(PF_MAX_SKIP)))
              skip_cnt <= skip_cnt + SKIP_W'(1);
          end else if (pf_win) begin
            skip_cnt <= '0;
            // A redundant prefetch is acknowledged but never reaches the L2.
            if (!pf_redundant) begin
              mem_addr_o <= pf_line;
              owner      <= 1'b1;
              state      <= S_ISSUE;
              busy_o     <= 1'b1;
              mem_re_o   <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          wait_cnt <= wait_nxt;
          if (mem_ready_i) begin
            rsp_data_o  <= mem_data_i;
            last_line   <= mem_addr_o;
            last_valid  <= 1'b1;
            dem_valid_o <= !owner;
            pf_valid_o  <= owner;
            state       <= S_RESP;
          end else if (wait_nxt == WAIT_W'(TIMEOUT)) begin
            timeout_o <= 1'b1;
            state     <= S_IDLE;
            busy_o    <= 1'b0;
          end
        end

        S_RESP: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end

        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_ifill_arbiter.sv
// Directed bench for l2_ifill_arbiter: each task drives one scenario and checks
// hand-computed expectations inline.
module tb_l2_ifill_arbiter;

  logic         clk;
  logic         reset;
  logic         run_i;
  logic         dem_req_i;
  logic [31:0]  dem_addr_i;
  logic         dem_gnt_o;
  logic         dem_valid_o;
  logic         pf_req_i;
  logic [31:0]  pf_addr_i;
  logic         pf_gnt_o;
  logic         pf_drop_o;
  logic         pf_valid_o;
  logic [255:0] rsp_data_o;
  logic         mem_re_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_i;
  logic         mem_ready_i;
  logic         busy_o;
  logic         timeout_o;

  int n_cmp;
  int n_bad;

  l2_ifill_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .run_i       (run_i),
    .dem_req_i   (dem_req_i),
    .dem_addr_i  (dem_addr_i),
    .dem_gnt_o   (dem_gnt_o),
    .dem_valid_o (dem_valid_o),
    .pf_req_i    (pf_req_i),
    .pf_addr_i   (pf_addr_i),
    .pf_gnt_o    (pf_gnt_o),
    .pf_drop_o   (pf_drop_o),
    .pf_valid_o  (pf_valid_o),
    .rsp_data_o  (rsp_data_o),
    .mem_re_o    (mem_re_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_i  (mem_data_i),
    .mem_ready_i (mem_ready_i),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run_i = 1'b0; dem_req_i = 1'b0; pf_req_i = 1'b0;
    dem_addr_i = '0; pf_addr_i = '0; mem_data_i = '0; mem_ready_i = 1'b0;
    tick(); tick(); tick();
    #1;
    n_cmp++;
    if ({dem_gnt_o, dem_valid_o, pf_gnt_o, pf_drop_o, pf_valid_o, mem_re_o, busy_o, timeout_o} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000000",
               {dem_gnt_o, dem_valid_o, pf_gnt_o, pf_drop_o, pf_valid_o, mem_re_o, busy_o, timeout_o});
    end
    n_cmp++;
    if ({mem_addr_o, rsp_data_o} !== 288'h0) begin
      n_bad++;
      $display("FAIL reset_data: got addr %h data %h want 0", mem_addr_o, rsp_data_o);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_demand();
    logic [255:0] d1;
    d1 = {8{32'h1111_0001}};
    run_i = 1'b1; dem_req_i = 1'b1; dem_addr_i = 32'h0000_1234;
    #1;
    n_cmp++;
    if ({dem_gnt_o, pf_gnt_o} !== 2'b10) begin
      n_bad++; $display("FAIL single_gnt: got %b want 10", {dem_gnt_o, pf_gnt_o});
    end
    tick();  // N+1
    dem_req_i = 1'b0;
    #1;
    n_cmp++;
    if ({mem_re_o, busy_o, dem_gnt_o} !== 3'b110) begin
      n_bad++; $display("FAIL single_issue: got %b want 110", {mem_re_o, busy_o, dem_gnt_o});
    end
    n_cmp++;
    if (mem_addr_o !== 32'h0000_1220) begin
      n_bad++; $display("FAIL single_addr: got %h want 00001220", mem_addr_o);
    end
    tick();  // N+2
    n_cmp++;
    if (mem_re_o !== 1'b0) begin
      n_bad++; $display("FAIL single_re_pulse: got %b want 0", mem_re_o);
    end
    tick();  // N+3: ready two cycles after the strobe
    mem_ready_i = 1'b1; mem_data_i = d1;
    tick();  // N+4
    mem_ready_i = 1'b0; mem_data_i = '0;
    #1;
    n_cmp++;
    if ({dem_valid_o, pf_valid_o} !== 2'b10 || rsp_data_o !== d1) begin
      n_bad++;
      $display("FAIL single_valid: got valid %b data %h want 10 data %h",
               {dem_valid_o, pf_valid_o}, rsp_data_o, d1);
    end
    tick();  // N+5
    n_cmp++;
    if ({dem_valid_o, busy_o} !== 2'b00 || rsp_data_o !== d1) begin
      n_bad++;
      $display("FAIL single_after: got valid/busy %b data %h want 00 data %h",
               {dem_valid_o, busy_o}, rsp_data_o, d1);
    end
  endtask

  task automatic test_arbitration();
    logic [255:0] d;
    logic [1:0]   exp;
    pf_addr_i = 32'h0000_8000;
    for (int i = 0; i < 6; i++) begin
      exp = (i == 4) ? 2'b01 : 2'b10;
      d = {8{32'hA000_0000 | 32'(i)}};
      dem_req_i = 1'b1; pf_req_i = 1'b1; dem_addr_i = 32'h0000_1000 + 32'(i) * 32'h100;
      #1;
      n_cmp++;
      if ({dem_gnt_o, pf_gnt_o, pf_drop_o} !== {exp, 1'b0}) begin
        n_bad++;
        $display("FAIL arb_gnt[%0d]: got %b want %b", i, {dem_gnt_o, pf_gnt_o, pf_drop_o}, {exp, 1'b0});
      end
      tick();  // ISSUE
      tick();  // WAIT
      mem_ready_i = 1'b1; mem_data_i = d;
      tick();  // RESP
      mem_ready_i = 1'b0;
      #1;
      n_cmp++;
      if ({dem_valid_o, pf_valid_o} !== exp || rsp_data_o !== d) begin
        n_bad++;
        $display("FAIL arb_valid[%0d]: got %b data %h want %b data %h",
                 i, {dem_valid_o, pf_valid_o}, rsp_data_o, exp, d);
      end
      tick();  // IDLE
    end
    dem_req_i = 1'b0; pf_req_i = 1'b0;
  endtask

  task automatic test_redundant_prefetch();
    logic [255:0] d3;
    logic [255:0] d4;
    d3 = {8{32'h3333_0003}};
    d4 = {8{32'h4444_0004}};
    dem_req_i = 1'b1; dem_addr_i = 32'h0000_2000;
    #1;
    tick();
    dem_req_i = 1'b0;
    tick();
    mem_ready_i = 1'b1; mem_data_i = d3;
    tick();
    mem_ready_i = 1'b0;
    tick();  // IDLE
    pf_req_i = 1'b1; pf_addr_i = 32'h0000_2010;
    #1;
    n_cmp++;
    if ({dem_gnt_o, pf_gnt_o, pf_drop_o} !== 3'b011) begin
      n_bad++; $display("FAIL drop_gnt: got %b want 011", {dem_gnt_o, pf_gnt_o, pf_drop_o});
    end
    tick();
    pf_req_i = 1'b0;
    #1;
    n_cmp++;
    if ({mem_re_o, busy_o, pf_valid_o} !== 3'b000) begin
      n_bad++; $display("FAIL drop_noaccess: got %b want 000", {mem_re_o, busy_o, pf_valid_o});
    end
    pf_req_i = 1'b1; pf_addr_i = 32'h0000_2020;
    #1;
    n_cmp++;
    if ({pf_gnt_o, pf_drop_o} !== 2'b10) begin
      n_bad++; $display("FAIL pf_new_gnt: got %b want 10", {pf_gnt_o, pf_drop_o});
    end
    tick();
    pf_req_i = 1'b0;
    #1;
    n_cmp++;
    if (mem_re_o !== 1'b1 || mem_addr_o !== 32'h0000_2020) begin
      n_bad++; $display("FAIL pf_new_issue: got re %b addr %h want 1 00002020", mem_re_o, mem_addr_o);
    end
    tick();
    mem_ready_i = 1'b1; mem_data_i = d4;
    tick();
    mem_ready_i = 1'b0;
    #1;
    n_cmp++;
    if ({dem_valid_o, pf_valid_o} !== 2'b01 || rsp_data_o !== d4) begin
      n_bad++;
      $display("FAIL pf_new_valid: got %b data %h want 01 data %h", {dem_valid_o, pf_valid_o}, rsp_data_o, d4);
    end
    tick();
  endtask

  task automatic test_timeout();
    logic [255:0] d5;
    int cnt;
    int k;
    logic saw_valid;
    logic early_to;
    d5 = {8{32'h5555_0005}};
    cnt = 0; k = 0; saw_valid = 1'b0; early_to = 1'b0;
    dem_req_i = 1'b1; dem_addr_i = 32'h0000_4000;
    #1;
    tick();  // ISSUE
    dem_req_i = 1'b0;
    while (busy_o === 1'b1 && k < 60) begin
      cnt++;
      if (dem_valid_o || pf_valid_o) saw_valid = 1'b1;
      if (timeout_o) early_to = 1'b1;
      tick();
      k++;
    end
    n_cmp++;
    if (cnt !== 32) begin
      n_bad++; $display("FAIL timeout_busy_cycles: got %0d want 32", cnt);
    end
    n_cmp++;
    if ({timeout_o, saw_valid, early_to} !== 3'b100) begin
      n_bad++; $display("FAIL timeout_flags: got %b want 100", {timeout_o, saw_valid, early_to});
    end
    tick(); tick(); tick();
    n_cmp++;
    if (timeout_o !== 1'b1) begin
      n_bad++; $display("FAIL timeout_sticky: got %b want 1", timeout_o);
    end
    dem_req_i = 1'b1; dem_addr_i = 32'h0000_5000;
    #1;
    tick();  // ISSUE
    dem_req_i = 1'b0;
    tick(); tick(); tick();
    mem_ready_i = 1'b1; mem_data_i = d5;
    tick();
    mem_ready_i = 1'b0;
    #1;
    n_cmp++;
    if ({dem_valid_o, timeout_o} !== 2'b11 || rsp_data_o !== d5) begin
      n_bad++;
      $display("FAIL timeout_refill: got valid/to %b data %h want 11 data %h", {dem_valid_o, timeout_o}, rsp_data_o, d5);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    logic saw;
    saw = 1'b0;
    dem_req_i = 1'b1; dem_addr_i = 32'h0000_6000;
    #1;
    tick();  // ISSUE
    dem_req_i = 1'b0;
    tick();  // WAIT
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({dem_valid_o, pf_valid_o, mem_re_o, busy_o, timeout_o} !== 5'b0 || mem_addr_o !== 32'h0 || rsp_data_o !== 256'h0) begin
      n_bad++;
      $display("FAIL rst_wait_clear: got %b addr %h data %h want 0",
               {dem_valid_o, pf_valid_o, mem_re_o, busy_o, timeout_o}, mem_addr_o, rsp_data_o);
    end
    reset = 1'b0;
    tick();
    mem_ready_i = 1'b1; mem_data_i = {8{32'h6666_0006}};
    tick();
    mem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (dem_valid_o || pf_valid_o || busy_o) saw = 1'b1;
      tick();
    end
    n_cmp++;
    if (saw !== 1'b0 || rsp_data_o !== 256'h0) begin
      n_bad++; $display("FAIL rst_late_ready: got activity %b data %h want 0", saw, rsp_data_o);
    end
  endtask

  task automatic test_run_gate();
    logic [255:0] d7;
    logic saw;
    d7 = {8{32'h7777_0007}};
    saw = 1'b0;
    run_i = 1'b0; dem_req_i = 1'b1; dem_addr_i = 32'h0000_7000;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (dem_gnt_o || pf_gnt_o || busy_o || mem_re_o) saw = 1'b1;
      tick();
    end
    n_cmp++;
    if (saw !== 1'b0) begin
      n_bad++; $display("FAIL run_block: got activity %b want 0", saw);
    end
    run_i = 1'b1;
    #1;
    n_cmp++;
    if (dem_gnt_o !== 1'b1) begin
      n_bad++; $display("FAIL run_gnt: got %b want 1", dem_gnt_o);
    end
    tick();  // ISSUE
    run_i = 1'b0; dem_req_i = 1'b0;
    tick();  // WAIT
    mem_ready_i = 1'b1; mem_data_i = d7;
    tick();  // RESP
    mem_ready_i = 1'b0;
    dem_req_i = 1'b1; dem_addr_i = 32'h0000_7100;
    #1;
    n_cmp++;
    if (dem_valid_o !== 1'b1 || rsp_data_o !== d7) begin
      n_bad++; $display("FAIL run_inflight: got %b data %h want 1 data %h", dem_valid_o, rsp_data_o, d7);
    end
    tick();  // IDLE, still not running
    #1;
    n_cmp++;
    if ({dem_gnt_o, busy_o} !== 2'b00) begin
      n_bad++; $display("FAIL run_no_rearb: got %b want 00", {dem_gnt_o, busy_o});
    end
    dem_req_i = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single_demand();
    test_arbitration();
    test_redundant_prefetch();
    test_timeout();
    test_reset_mid_wait();
    test_run_gate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
